// File: rtl/id_front_stage_if.sv
// IF/ID front-stage bundle: stall/flush control, IF slot, SRAM word, forwarding channels,
// EX load info in; decoded ID slot, forwarded operands, interlock and redirect out.
interface id_front_stage_if #(
  parameter int FWD_CH  = 3,
  parameter int STALL_W = 6
);
  logic [STALL_W-1:0]  stall;
  logic                flush;
  logic                if_ce;
  logic [31:0]         if_pc;
  logic [31:0]         inst_sram_rdata;
  logic [FWD_CH-1:0]   fwd_we;
  logic [5*FWD_CH-1:0] fwd_waddr;
  logic [32*FWD_CH-1:0] fwd_wdata;
  logic                ex_is_load;
  logic [4:0]          ex_load_waddr;

  logic                id_valid;
  logic [31:0]         id_pc;
  logic [31:0]         id_inst;
  logic [31:0]         rdata1;
  logic [31:0]         rdata2;
  logic                stallreq;
  logic                br_taken;
  logic [31:0]         br_target;

  modport master (
    output stall, flush, if_ce, if_pc, inst_sram_rdata,
    output fwd_we, fwd_waddr, fwd_wdata, ex_is_load, ex_load_waddr,
    input  id_valid, id_pc, id_inst, rdata1, rdata2, stallreq, br_taken, br_target
  );

  modport slave (
    input  stall, flush, if_ce, if_pc, inst_sram_rdata,
    input  fwd_we, fwd_waddr, fwd_wdata, ex_is_load, ex_load_waddr,
    output id_valid, id_pc, id_inst, rdata1, rdata2, stallreq, br_taken, br_target
  );
endinterface

// File: rtl/id_front_stage.sv
// MIPS ID front half: IF/ID register with SRAM word hold, forwarded regfile, load-use interlock, branch resolve.
// Latency 1 cycle from IF; outputs combinational from ID state. Backpressure via stall vector; stallreq on load-use.
module id_front_stage #(
  parameter int FWD_CH  = 3,
  parameter int STALL_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  id_front_stage_if.slave   bus
);
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_LUI     = 6'h0F, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_JR      = 6'h08, FN_JALR   = 6'h09;
  localparam logic [4:0] RI_BLTZ    = 5'h00, RI_BGEZ   = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11;

  logic [STALL_W-1:0] stall_v;
  logic               stall_unused;
  logic               stall_ifid, stall_id;
  logic               id_valid;
  logic [31:0]        id_pc, hold_inst, raw, inst;
  logic               hold_v;
  logic [31:0]        rf [32];

  assign stall_v      = bus.stall;
  assign stall_ifid   = stall_v[1];
  assign stall_id     = stall_v[2];
  assign stall_unused = ^{stall_v[STALL_W-1:3], stall_v[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid  <= 1'b0;
      id_pc     <= '0;
      hold_v    <= 1'b0;
      hold_inst <= '0;
    end else if (bus.flush) begin
      id_valid <= 1'b0;
      hold_v   <= 1'b0;
    end else if (stall_ifid && !stall_id) begin
      id_valid <= 1'b0;
      hold_v   <= 1'b0;
    end else if (!stall_ifid) begin
      id_valid <= bus.if_ce;
      id_pc    <= bus.if_pc;
      hold_v   <= 1'b0;
    end else if (id_valid && !hold_v) begin
      // SRAM output is only valid the cycle after fetch; latch it for the rest of the stall
      hold_inst <= bus.inst_sram_rdata;
      hold_v    <= 1'b1;
    end
  end

  assign raw  = hold_v ? hold_inst : bus.inst_sram_rdata;
  assign inst = id_valid ? raw : 32'h0;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  assign opcode = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign imm    = inst[15:0];
  assign funct  = inst[5:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.fwd_we[FWD_CH-1] && bus.fwd_waddr[5*(FWD_CH-1) +: 5] != 5'd0) begin
      rf[bus.fwd_waddr[5*(FWD_CH-1) +: 5]] <= bus.fwd_wdata[32*(FWD_CH-1) +: 32];
    end
  end

  logic [31:0] op1, op2;
  // Scan oldest to youngest so the lowest-index match overwrites the rest
  always_comb begin
    op1 = rf[rs];
    op2 = rf[rt];
    for (int k = FWD_CH - 1; k >= 0; k--) begin
      if (bus.fwd_we[k] && bus.fwd_waddr[5*k +: 5] == rs) op1 = bus.fwd_wdata[32*k +: 32];
      if (bus.fwd_we[k] && bus.fwd_waddr[5*k +: 5] == rt) op2 = bus.fwd_wdata[32*k +: 32];
    end
    if (rs == 5'd0) op1 = '0;
    if (rt == 5'd0) op2 = '0;
  end

  logic uses_rs, uses_rt, stallreq;
  assign uses_rs  = id_valid && !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI);
  assign uses_rt  = id_valid && (opcode == OP_SPECIAL || opcode == OP_BEQ || opcode == OP_BNE ||
                                 opcode == OP_SB || opcode == OP_SH || opcode == OP_SW);
  assign stallreq = bus.ex_is_load && bus.ex_load_waddr != 5'd0 &&
                    ((uses_rs && bus.ex_load_waddr == rs) || (uses_rt && bus.ex_load_waddr == rt));

  logic [31:0] pc4, boff, tgt;
  logic        cond, taken;
  assign pc4  = id_pc + 32'd4;
  assign boff = pc4 + {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    cond = 1'b0;
    tgt  = boff;
    case (opcode)
      OP_SPECIAL: if (funct == FN_JR || funct == FN_JALR) begin
        cond = 1'b1;
        tgt  = op1;
      end
      OP_REGIMM: case (rt)
        RI_BLTZ, RI_BLTZAL: cond = op1[31];
        RI_BGEZ, RI_BGEZAL: cond = ~op1[31];
        default:            cond = 1'b0;
      endcase
      OP_J, OP_JAL: begin
        cond = 1'b1;
        tgt  = {id_pc[31:28], inst[25:0], 2'b00};
      end
      OP_BEQ:  cond = (op1 == op2);
      OP_BNE:  cond = (op1 != op2);
      OP_BLEZ: cond = op1[31] || (op1 == 32'h0);
      OP_BGTZ: cond = !op1[31] && (op1 != 32'h0);
      default: cond = 1'b0;
    endcase
  end

  assign taken = id_valid && !stallreq && cond;

  assign bus.id_valid  = id_valid;
  assign bus.id_pc     = id_pc;
  assign bus.id_inst   = inst;
  assign bus.rdata1    = op1;
  assign bus.rdata2    = op2;
  assign bus.stallreq  = stallreq;
  assign bus.br_taken  = taken;
  assign bus.br_target = taken ? tgt : 32'h0;
endmodule

// File: tb/tb_id_front_stage.sv
// Directed bench for id_front_stage: stimulus pushes expected ID outputs, a negedge monitor pops and compares.
module tb_id_front_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_front_stage_if #(.FWD_CH(3), .STALL_W(6)) bus ();
  id_front_stage #(.FWD_CH(3), .STALL_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [7:0]  mask;  // 0 valid,1 pc,2 inst,3 r1,4 r2,5 stallreq,6 taken,7 target
    logic        v;
    logic [31:0] pc, inst, r1, r2;
    logic        sr, bt;
    logic [31:0] tgt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic cmp(input string nm, input string fld, input logic en, input logic [31:0] act, input logic [31:0] ref_v);
    if (en) begin
      n_checks++;
      if (act !== ref_v) begin
        n_fail++;
        $display("FAIL %s.%s: got %h expected %h", nm, fld, act, ref_v);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      cmp(n, "id_valid",  e.mask[0], {31'b0, bus.id_valid}, {31'b0, e.v});
      cmp(n, "id_pc",     e.mask[1], bus.id_pc,     e.pc);
      cmp(n, "id_inst",   e.mask[2], bus.id_inst,   e.inst);
      cmp(n, "rdata1",    e.mask[3], bus.rdata1,    e.r1);
      cmp(n, "rdata2",    e.mask[4], bus.rdata2,    e.r2);
      cmp(n, "stallreq",  e.mask[5], {31'b0, bus.stallreq}, {31'b0, e.sr});
      cmp(n, "br_taken",  e.mask[6], {31'b0, bus.br_taken}, {31'b0, e.bt});
      cmp(n, "br_target", e.mask[7], bus.br_target, e.tgt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue one expectation, let the monitor see it at the negedge, then advance one cycle
  task automatic chk(input string nm, input logic [7:0] m, input logic v, input logic [31:0] pc,
                     input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                     input logic sr, input logic bt, input logic [31:0] tgt);
    exp_t e;
    e = '{mask: m, v: v, pc: pc, inst: inst, r1: r1, r2: r2, sr: sr, bt: bt, tgt: tgt};
    exp_q.push_back(e);
    name_q.push_back(nm);
    tick();
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] inst);
    bus.stall = 6'b000000;
    bus.if_ce = 1'b1;
    bus.if_pc = pc;
    tick();
    bus.inst_sram_rdata = inst;
    bus.stall = 6'b000110;
    bus.if_ce = 1'b0;
    bus.if_pc = 32'h0;
  endtask

  initial begin
    bus.stall = '0; bus.flush = 1'b0; bus.if_ce = 1'b0; bus.if_pc = '0;
    bus.inst_sram_rdata = 32'h2408_0001;
    bus.fwd_we = '0; bus.fwd_waddr = '0; bus.fwd_wdata = '0;
    bus.ex_is_load = 1'b0; bus.ex_load_waddr = '0;
    #1;
    chk("reset", 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    // Write-back: $9 = 0x1234, attempt $0 = 0xBEEF
    bus.fwd_we = 3'b100;
    bus.fwd_waddr = {5'd9, 5'd0, 5'd0}; bus.fwd_wdata = {32'h1234, 64'h0};
    tick();
    bus.fwd_waddr = {5'd0, 5'd0, 5'd0}; bus.fwd_wdata = {32'hBEEF, 64'h0};
    tick();
    bus.fwd_we = 3'b000;

    load(32'h0040_0000, 32'h00A5_0821);  // addu $1,$5,$5
    bus.fwd_we = 3'b111;
    bus.fwd_waddr = {5'd5, 5'd5, 5'd5};
    bus.fwd_wdata = {32'h33, 32'h22, 32'h11};
    chk("fwd_ch0", 8'h1F, 1, 32'h0040_0000, 32'h00A5_0821, 32'h11, 32'h11, 0, 0, 0);
    bus.fwd_we = 3'b110;
    chk("fwd_ch1", 8'h18, 0, 0, 0, 32'h22, 32'h22, 0, 0, 0);
    bus.fwd_we = 3'b000;
    chk("rf_read5", 8'h18, 0, 0, 0, 32'h33, 32'h33, 0, 0, 0);

    load(32'h0040_0010, 32'h0000_1021);  // addu $2,$0,$0
    bus.fwd_we = 3'b001; bus.fwd_waddr = '0; bus.fwd_wdata = {64'h0, 32'hDEAD};
    chk("r0_fwd", 8'h18, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.fwd_we = 3'b000;
    load(32'h0040_0014, 32'h0120_1021);  // addu $2,$9,$0
    chk("rf_r9_r0", 8'h18, 0, 0, 0, 32'h1234, 0, 0, 0, 0);

    load(32'h0040_0100, 32'h1109_0010);  // beq $8,$9,+16
    bus.ex_is_load = 1'b1; bus.ex_load_waddr = 5'd8;
    chk("loaduse_stall", 8'hE0, 0, 0, 0, 0, 0, 1, 0, 0);
    bus.ex_is_load = 1'b0;
    bus.fwd_we = 3'b010; bus.fwd_waddr = {5'd0, 5'd8, 5'd0}; bus.fwd_wdata = {32'h0, 32'h1234, 32'h0};
    chk("loaduse_retry", 8'hF8, 0, 0, 0, 32'h1234, 32'h1234, 0, 1, 32'h0040_0144);
    bus.fwd_we = 3'b000;
    load(32'h0040_0108, 32'h3C08_0005);  // lui $8,5
    bus.ex_is_load = 1'b1; bus.ex_load_waddr = 5'd8;
    chk("lui_nostall", 8'h21, 1, 0, 0, 0, 0, 0, 0, 0);
    bus.ex_is_load = 1'b0;

    load(32'h0040_0200, 32'h2408_0001);
    chk("hold0", 8'h06, 0, 32'h0040_0200, 32'h2408_0001, 0, 0, 0, 0, 0);
    bus.inst_sram_rdata = 32'hFFFF_FFFF;
    chk("hold1", 8'h06, 0, 32'h0040_0200, 32'h2408_0001, 0, 0, 0, 0, 0);
    chk("hold2", 8'h06, 0, 32'h0040_0200, 32'h2408_0001, 0, 0, 0, 0, 0);
    bus.stall = 6'b000000; bus.if_ce = 1'b1; bus.if_pc = 32'h0040_0204;
    chk("hold_release", 8'h06, 0, 32'h0040_0200, 32'h2408_0001, 0, 0, 0, 0, 0);
    bus.inst_sram_rdata = 32'h3C09_0007; bus.stall = 6'b000110; bus.if_ce = 1'b0;
    chk("next_pc", 8'h07, 1, 32'h0040_0204, 32'h3C09_0007, 0, 0, 0, 0, 0);

    bus.stall = 6'b000010;
    tick();
    chk("bubble", 8'h05, 0, 0, 0, 0, 0, 0, 0, 0);
    load(32'h0040_0220, 32'h2408_0001);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_stall", 8'h05, 0, 0, 0, 0, 0, 0, 0, 0);

    bus.fwd_we = 3'b001; bus.fwd_waddr = {10'd0, 5'd4}; bus.fwd_wdata = {64'h0, 32'h8000_0000};
    load(32'h0040_0300, 32'h0490_0004);  // bltzal $4
    chk("bltzal_neg", 8'hC9, 1, 0, 0, 32'h8000_0000, 0, 0, 1, 32'h0040_0314);
    load(32'h0040_0300, 32'h0481_0004);  // bgez $4
    chk("bgez_neg", 8'hC9, 1, 0, 0, 32'h8000_0000, 0, 0, 0, 0);
    load(32'h0040_0300, 32'h1880_FFFF);  // blez $4,-1
    chk("blez_neg", 8'hC9, 1, 0, 0, 32'h8000_0000, 0, 0, 1, 32'h0040_0300);
    bus.fwd_wdata = '0;
    load(32'h0040_0300, 32'h1C80_0004);  // bgtz $4
    chk("bgtz_zero", 8'hC9, 1, 0, 0, 0, 0, 0, 0, 0);
    load(32'h0040_0300, 32'h1880_0004);  // blez $4
    chk("blez_zero", 8'hC9, 1, 0, 0, 0, 0, 0, 1, 32'h0040_0314);
    bus.fwd_wdata = {64'h0, 32'h0040_0100};
    load(32'h0040_0300, 32'h0080_F809);  // jalr $4
    chk("jalr", 8'hC9, 1, 0, 0, 32'h0040_0100, 0, 0, 1, 32'h0040_0100);
    bus.fwd_we = 3'b000;
    load(32'hA040_0300, 32'h0810_0040);  // j
    chk("j_region", 8'hC1, 1, 0, 0, 0, 0, 0, 1, 32'hA040_0100);
    load(32'hFFFF_FFFC, 32'h1000_0001);  // beq $0,$0,+1
    chk("beq_wrap", 8'hC1, 1, 0, 0, 0, 0, 0, 1, 32'h0000_0004);

    load(32'hA040_0300, 32'h0810_0040);
    tick();
    rst = 1'b0;
    chk("reset_mid", 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    load(32'h0040_0000, 32'h0120_1021);  // addu $2,$9,$0 after regfile clear
    chk("rf_cleared", 8'h09, 1, 0, 0, 0, 0, 0, 0, 0);

    tick();
    tick();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_front_stage.md
# id_front_stage

Parametrised instruction-decode front half for the 5-stage MIPS pipeline, sitting between IF and the EX-side decoder. Holds the IF/ID pipeline register and an instruction hold register that keeps the SRAM word stable across stalls. Provides a zero-register-aware regfile with N-channel forwarding and a precise load-use interlock. Resolves all MIPS-I branches and jumps.

## Interface
- FWD_CH, 3, forwarding channels; index 0 has highest priority (youngest stage); channel FWD_CH-1 also writes the regfile.
- STALL_W, 6, stall bus width; bit 1 = IF/ID, bit 2 = ID.
- clk  in  1  clock.
- rst  in  1  reset; one clock, reset asynchronous and active-low.
- stall  in  STALL_W  pipeline stall vector, 1 = stop.
- flush  in  1  kill the ID slot (exception/redirect).
- if_ce  in  1  IF slot valid.
- if_pc  in  32  IF slot PC.
- inst_sram_rdata  in  32  synchronous SRAM instruction word for the slot now in ID.
- fwd_we  in  FWD_CH  per-channel write enable.
- fwd_waddr  in  5*FWD_CH  per-channel destination; channel k at [5k+4:5k].
- fwd_wdata  in  32*FWD_CH  per-channel data.
- ex_is_load  in  1  instruction in EX is a load.
- ex_load_waddr  in  5  destination of that load.
- id_valid  out  1  ID slot valid.
- id_pc  out  32  ID PC.
- id_inst  out  32  ID instruction; 0 when !id_valid.
- rdata1 / rdata2  out  32  forwarded rs / rt operands.
- stallreq  out  1  load-use interlock request.
- br_taken  out  1  redirect IF.
- br_target  out  32  redirect address.

## Operation
- ID register priority, evaluated at posedge clk: rst low → id_valid=0, id_pc=0, hold_v=0 (asynchronous); flush → id_valid=0, hold_v=0; stall[1]=1 & stall[2]=0 → bubble, id_valid=0; stall[1]=0 → id_valid<=if_ce, id_pc<=if_pc, hold_v<=0; otherwise hold.
- Instruction hold: raw = hold_v ? hold_inst : inst_sram_rdata. On a posedge with stall[2]=1, id_valid=1, and hold_v=0, capture hold_inst<=inst_sram_rdata and set hold_v=1. id_inst = id_valid ? raw : 0.
- Regfile: 32×32 cleared on reset. Written at posedge by channel FWD_CH-1 when we=1 and waddr≠0. r0 always reads 0.
- Forwarding per operand: address 0 → 0. Otherwise the lowest-index channel k with we[k] and waddr[k]==addr supplies the value. With no match, the regfile value is used.
- uses_rs = id_valid & opcode∉{J, JAL, LUI}.
- uses_rt = id_valid & (opcode∈{SPECIAL, BEQ, BNE} or any store SB/SH/SW).
- stallreq = ex_is_load & ex_load_waddr≠0 & ((uses_rs & ex_load_waddr==rs) | (uses_rt & ex_load_waddr==rt)).
- Branches: pc4=id_pc+4; boff=pc4+sext(imm)<<2.
  - BEQ/BNE use rs==rt / rs≠rt.
  - BGEZ and BGEZAL use rs[31]=0; BLTZ and BLTZAL use rs[31]=1.
  - BGTZ uses rs[31]=0 & rs≠0; BLEZ uses rs[31]=1 | rs==0.
  - J/JAL always taken, target {id_pc[31:28], index, 2'b0}.
  - JR/JALR always taken, target rdata1.
- br_taken = id_valid & ~stallreq & condition. br_target = 0 when not taken.
- Arithmetic is 32-bit modulo; target wrap at 0xFFFFFFFC is not trapped.

## Timing
- Reset values: id_valid 0, id_pc 0, id_inst 0, rdata1/2 0, stallreq 0, br_taken 0, br_target 0.
- ID register latency: 1 cycle from IF. All outputs are combinational from ID state, raw, and forwarding inputs within the same cycle.
- Regfile write-then-read in the same cycle is covered by forwarding of channel FWD_CH-1, not write-through.
- stallreq asserts in the same cycle the dependent instruction sits in ID. br_taken is held low for that cycle and evaluates on the retry cycle with forwarded data.
- Simultaneous flush and stall: flush wins.
- Reset mid-stall clears hold_v immediately.

## Test plan
- Forward priority: fwd_we=3'b111, all waddr=5, data 0x11/0x22/0x33; ID holds `addu $1,$5,$5` → rdata1=rdata2=0x11. Drop we[0] → 0x22.
- r0: fwd channel 0 writes addr 0 with 0xDEAD; instruction reads $0 → rdata1=0. Regfile read of $0 after a WB write to $0 → 0.
- Load-use: ex_is_load=1, ex_load_waddr=8; ID `beq $8,$9` → stallreq=1, br_taken=0. Next cycle ex_is_load=0 with 8 forwarded equal to $9 → br_taken=1, target=pc4+offset. `lui $8` with the same EX state → stallreq=0.
- Hold: stall[2]=1 for 3 cycles starting with SRAM word 0x24080001; SRAM then changes to 0xFFFFFFFF → id_inst stays 0x24080001 throughout. On release, the next if_pc loads.
- Bubble/flush: stall[1]=1, stall[2]=0 → id_valid=0, id_inst=0. flush asserted together with stall → id_valid=0.
- Branch set: rs=0x80000000 → BLTZAL taken, BGEZ not, BLEZ taken. rs=0 → BGTZ not, BLEZ taken. JALR with rs=0x00400100 → target 0x00400100. Deassert rst mid-run → all outputs return to 0 immediately.
